fp32_div_seq: RTL and testbench

//  Iterative IEEE-754 single-precision divider: result = a_operand / b_operand.

---
 rtl/fp32_pkg.sv | 33 +++
 rtl/fp32_div_seq_if.sv | 26 ++
 rtl/fp32_mant_div_seq.sv | 59 +++++
 rtl/fp32_div_seq.sv | 131 +++++++++++++
 tb/tb_fp32_div_seq.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: field layout, exponent constants, divider FSM states.
// Combinational helpers only, no latency.
// No flow control; imported by the divider and the multiplier bench.
package fp32_pkg;

  localparam int         FP32_BIAS    = 127;
  localparam logic [7:0] FP32_EXP_MAX = 8'hFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  // Special-case class decided at accept time.
  typedef enum logic [1:0] {K_NONE, K_EXC, K_DBZ, K_AZERO} kind_t;

  function automatic fp32_t fp32_unpack(input logic [31:0] x);
    return fp32_t'(x);
  endfunction

  function automatic logic fp32_exp_is_max(input logic [7:0] e);
    return e == FP32_EXP_MAX;
  endfunction

  // Flush-to-zero: any operand with a zero exponent field counts as zero.
  function automatic logic fp32_exp_is_zero(input logic [7:0] e);
    return e == 8'h00;
  endfunction

endpackage

// File: rtl/fp32_div_seq_if.sv
// Operand/result handshake bundle for the sequential FP32 divider.
// No latency; wires only.
// Valid/ready on both the operand and the result side.
interface fp32_div_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        Exception;
  logic        Overflow;
  logic        Underflow;
  logic        DivByZero;

  modport master (
    output in_valid, a_operand, b_operand, out_ready,
    input  in_ready, out_valid, result, Exception, Overflow, Underflow, DivByZero
  );

  modport slave (
    input  in_valid, a_operand, b_operand, out_ready,
    output in_ready, out_valid, result, Exception, Overflow, Underflow, DivByZero
  );
endinterface

// File: rtl/fp32_mant_div_seq.sv
// Restoring mantissa divider, one quotient bit per cycle, MSB first.
// APPROX_BITS cycles after start; done is high during the final iteration.
// No backpressure: start is only issued when idle, q holds until the next start.
module fp32_mant_div_seq #(
  parameter int APPROX_BITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] ma,
  input  logic [23:0] mb,
  output logic        done,
  output logic [24:0] q
);

  localparam logic [4:0] Q_TOP    = 5'd24;
  localparam logic [4:0] LAST_CNT = 5'(APPROX_BITS - 1);

  logic [25:0] rem;
  logic [23:0] mb_q;
  logic [4:0]  cnt;
  logic        busy;
  logic        borrow;
  logic [25:0] trial;

  assign done = busy && (cnt == LAST_CNT);

  // Trial subtraction of the divisor from the partial remainder.
  always_comb begin
    {borrow, trial} = {1'b0, rem} - {3'b000, mb_q};
  end

  // Iteration: keep the difference when it did not borrow, shift, record the bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      mb_q <= '0;
      q    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= {2'b00, ma};
      mb_q <= mb;
      q    <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (!borrow) begin
        rem           <= trial << 1;
        q[Q_TOP - cnt] <= 1'b1;
      end else begin
        rem <= rem << 1;
      end
      cnt <= cnt + 5'd1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/fp32_div_seq.sv
// Sequential FP32 divider a/b, truncating, flush-to-zero, with special-case flags.
// Specials: out_valid one edge after accept; normal: APPROX_BITS+1 edges after accept.
// One op in flight; in_ready only in IDLE; result and flags held until out_ready.
module fp32_div_seq
  import fp32_pkg::*;
#(
  parameter int APPROX_BITS = 25
) (
  input  logic           clk,
  input  logic           rst,
  fp32_div_seq_if.slave  bus
);

  state_t      state;
  kind_t       kind_in, kind_q;
  fp32_t       a_in, b_in;
  logic        sign_q;
  logic [7:0]  ea_q, eb_q;
  logic        start;
  logic        core_done;
  logic [24:0] q;
  logic signed [9:0] e_raw, e_adj;
  logic [22:0] frac_n;

  assign a_in  = fp32_unpack(bus.a_operand);
  assign b_in  = fp32_unpack(bus.b_operand);
  assign start = (state == IDLE) && bus.in_valid && (kind_in == K_NONE);

  // Classify incoming operands in priority order: NaN/Inf, divide by zero, zero dividend.
  always_comb begin
    kind_in = K_NONE;
    if (fp32_exp_is_max(a_in.exp) || fp32_exp_is_max(b_in.exp)) kind_in = K_EXC;
    else if (fp32_exp_is_zero(b_in.exp))                       kind_in = K_DBZ;
    else if (fp32_exp_is_zero(a_in.exp))                       kind_in = K_AZERO;
  end

  fp32_mant_div_seq #(.APPROX_BITS(APPROX_BITS)) u_mant (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ma    ({1'b1, a_in.frac}),
    .mb    ({1'b1, b_in.frac}),
    .done  (core_done),
    .q     (q)
  );

  // Exponent difference and single-step normalisation of the quotient (in [0.5, 2)).
  always_comb begin
    e_raw  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'(FP32_BIAS);
    e_adj  = e_raw;
    frac_n = q[23:1];
    if (!q[24]) begin
      e_adj  = e_raw - 10'sd1;
      frac_n = q[22:0];
    end
  end

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      kind_q        <= K_NONE;
      sign_q        <= 1'b0;
      ea_q          <= '0;
      eb_q          <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.Exception <= 1'b0;
      bus.Overflow  <= 1'b0;
      bus.Underflow <= 1'b0;
      bus.DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            kind_q        <= kind_in;
            sign_q        <= a_in.sign ^ b_in.sign;
            ea_q          <= a_in.exp;
            eb_q          <= b_in.exp;
            bus.in_ready  <= 1'b0;
            bus.result    <= '0;
            bus.Exception <= 1'b0;
            bus.Overflow  <= 1'b0;
            bus.Underflow <= 1'b0;
            bus.DivByZero <= 1'b0;
            state         <= (kind_in == K_NONE) ? DIV : NORM;
          end
        end
        DIV: begin
          if (core_done) state <= NORM;
        end
        NORM: begin
          case (kind_q)
            K_EXC: begin
              bus.result    <= '0;
              bus.Exception <= 1'b1;
            end
            K_DBZ: begin
              bus.result    <= {sign_q, FP32_EXP_MAX, 23'd0};
              bus.DivByZero <= 1'b1;
            end
            K_AZERO: bus.result <= {sign_q, 31'd0};
            default: begin
              if (e_adj >= 10'sd255) begin
                bus.result   <= {sign_q, FP32_EXP_MAX, 23'd0};
                bus.Overflow <= 1'b1;
              end else if (e_adj <= 10'sd0) begin
                bus.result    <= {sign_q, 31'd0};
                bus.Underflow <= 1'b1;
              end else begin
                bus.result <= {sign_q, e_adj[7:0], frac_n};
              end
            end
          endcase
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_div_seq.sv
// Directed and model-checked bench for fp32_div_seq (full-precision and 12-bit approximate).
// Latency measured in edges from the accept edge.
// Exercises result backpressure and mid-operation reset.
module tb_fp32_div_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp32_div_seq_if bus();
  fp32_div_seq_if bus12();

  fp32_div_seq #(.APPROX_BITS(25)) u_dut   (.clk(clk), .rst(rst), .bus(bus.slave));
  fp32_div_seq #(.APPROX_BITS(12)) u_dut12 (.clk(clk), .rst(rst), .bus(bus12.slave));

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Truncating reference: quotient taken as floor(ma * 2^24 / mb).
  function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e;
    logic [63:0] ma, mb, qq;
    logic [31:0] r;
    logic [3:0] f;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    f  = 4'b0000;
    r  = 32'd0;
    if (ea == 255 || eb == 255) begin
      f = 4'b1000;
    end else if (eb == 0) begin
      r = {s, 8'hFF, 23'd0};
      f = 4'b0001;
    end else if (ea == 0) begin
      r = {s, 31'd0};
    end else begin
      ma = 64'({1'b1, a[22:0]});
      mb = 64'({1'b1, b[22:0]});
      qq = (ma << 24) / mb;
      e  = ea - eb + 127;
      if (qq < (64'd1 << 24)) begin
        qq = qq << 1;
        e  = e - 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        f = 4'b0100;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        f = 4'b0010;
      end else begin
        r = {s, 8'(e), qq[23:1]};
      end
    end
    return {f, r};
  endfunction

  // Issue one op, return at the negedge where out_valid is first seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [3:0] fl, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid  = 1'b1;
    bus.a_operand = a;
    bus.b_operand = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) check_val("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
    res = bus.result;
    fl  = {bus.Exception, bus.Overflow, bus.Underflow, bus.DivByZero};
  endtask

  task automatic do_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [3:0] exp_fl, input int exp_lat);
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
    run_op(a, b, res, fl, lat);
    check_val({tag, "_res"}, res, exp_res);
    check_val({tag, "_flags"}, {28'd0, fl}, {28'd0, exp_fl});
    check_val({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    logic [31:0] res, ra, rb;
    logic [3:0]  fl;
    logic [35:0] exp_v;
    logic        seen;
    int          lat;

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.a_operand   = '0;
    bus.b_operand   = '0;
    bus.out_ready   = 1'b1;
    bus12.in_valid  = 1'b0;
    bus12.a_operand = '0;
    bus12.b_operand = '0;
    bus12.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("rst_result", bus.result, 32'd0);
    check_val("rst_flags", {28'd0, bus.Exception, bus.Overflow, bus.Underflow, bus.DivByZero}, 32'd0);
    rst = 1'b0;

    // Directed vectors: flags are {Exception, Overflow, Underflow, DivByZero}.
    do_vec("six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 26);
    do_vec("one_third",    32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 26);
    do_vec("neg_six_two",  32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 26);
    do_vec("div_zero",     32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001, 1);
    do_vec("neg_div_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0001, 1);
    do_vec("overflow",     32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0100, 26);
    do_vec("underflow",    32'h00800000, 32'h7F000000, 32'h00000000, 4'b0010, 26);
    do_vec("exc_a_inf",    32'h7F800000, 32'h3F800000, 32'h00000000, 4'b1000, 1);
    do_vec("exc_b_inf",    32'h00000000, 32'h7F800000, 32'h00000000, 4'b1000, 1);
    do_vec("neg_zero_a",   32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 1);

    // Approximate instance: only 12 quotient bits.
    @(negedge clk);
    bus12.in_valid  = 1'b1;
    bus12.a_operand = 32'h3F800000;
    bus12.b_operand = 32'h40400000;
    @(posedge clk);
    @(negedge clk);
    bus12.in_valid = 1'b0;
    lat = 0;
    while (!bus12.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_val("approx12_res", bus12.result, 32'h3EAAA000);
    check_val("approx12_lat", lat, 13);

    // Result backpressure: output frozen, no new accept.
    bus.out_ready = 1'b0;
    run_op(32'h40C00000, 32'h40000000, res, fl, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("hold_res", bus.result, 32'h40400000);
      check_val("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check_val("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("release_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Reset during DIV aborts the operation.
    bus.in_valid  = 1'b1;
    bus.a_operand = 32'h40C00000;
    bus.b_operand = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_val("mid_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_val("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    check_val("abort_no_result", {31'd0, seen}, 32'd0);

    // Back-to-back random normal operands against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra = {1'($urandom_range(1, 0)), 8'($urandom_range(254, 1)), 23'($urandom)};
      rb = {1'($urandom_range(1, 0)), 8'($urandom_range(254, 1)), 23'($urandom)};
      exp_v = ref_div(ra, rb);
      run_op(ra, rb, res, fl, lat);
      check_val("rand_res", res, exp_v[31:0]);
      check_val("rand_flags", {28'd0, fl}, {28'd0, exp_v[35:32]});
      check_val("rand_lat", lat, 26);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
